pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter unit for the pipelined MIPS core. It generalises the plain enable-gated PC register with the following:
- internal next-PC selection: sequential, branch, jump, exception, eret
- an EPC register
- stall handling that latches a redirect which arrives while fetch is frozen
- alignment checking of redirect targets

It sits at the head of IF and feeds the instruction memory address and the IF/ID pc+4 field.

Parameters:
- WIDTH, 32, PC/address width in bits (>= 8).
- INSTR_BYTES, 4, sequential increment; must be a power of 2.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- EXC_VECTOR, 32'h0000_0080, PC value loaded on exception.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  freeze PC (hazard unit).
- branch_taken_i  in  1  taken branch redirect request.
- branch_target_i  in  WIDTH  branch target.
- jump_i  in  1  jump/jr redirect request.
- jump_target_i  in  WIDTH  jump target.
- exc_i  in  1  exception request.
- exc_pc_i  in  WIDTH  PC of the faulting instruction; captured into EPC.
- eret_i  in  1  return from exception.
- pc_o  out  WIDTH  current fetch PC.
- pc_plus_o  out  WIDTH  pc_o + INSTR_BYTES, combinational from pc_o.
- pc_valid_o  out  1  pc_o holds a fetchable address.
- epc_o  out  WIDTH  exception PC register.
- redirect_pending_o  out  1  a redirect is latched and waiting for the stall to release.
- misaligned_o  out  1  one-cycle pulse when an applied target had nonzero low bits.

Behaviour:
- Reset: synchronous, active-high, on clk; clk is the only clock.
  - Values on reset: pc_o=RESET_VECTOR, epc_o=0, pc_valid_o=0, redirect_pending_o=0, misaligned_o=0, state=RUN.
  - Reset overrides every other input, including mid-stall or with a redirect pending; the pending redirect is discarded.
- pc_valid_o goes to 1 on the first clock after reset deasserts and stays 1 until the next reset.
- Request priority, highest first: exc_i > eret_i > branch_taken_i > jump_i > sequential. Only the highest asserted request is acted on.
- Exception:
  - Applies regardless of stall_i.
  - Next-cycle effects: pc_o=EXC_VECTOR, epc_o=exc_pc_i.
  - Clears any pending redirect; state goes to RUN.
- epc_o changes only on reset or on an exception.
- Redirect target per request: eret -> epc_o, branch -> branch_target_i, jump -> jump_target_i.
- Alignment: the applied target has its low log2(INSTR_BYTES) bits forced to 0. misaligned_o=1 in the cycle after application if any of those bits were 1; otherwise misaligned_o=0. EXC_VECTOR and the sequential path never raise misaligned_o.
- State RUN, stall_i=0:
  - If a redirect is requested, pc_o <= target.
  - Otherwise pc_o <= pc_o + INSTR_BYTES, modulo 2^WIDTH (wraps silently).
- State RUN, stall_i=1:
  - pc_o holds.
  - If a redirect is requested, latch the aligned target and its misaligned flag into the pending register, go to HOLD, and set redirect_pending_o=1 in the next cycle.
- State HOLD, stall_i=1:
  - pc_o holds.
  - A new non-exception redirect overwrites the pending target (latest wins).
  - A cycle with no request leaves the pending target unchanged.
- State HOLD, stall_i=0:
  - pc_o <= pending target, redirect_pending_o <= 0, state <= RUN.
  - misaligned_o pulses here if the pending flag was set.
  - A simultaneous live redirect in this cycle takes precedence over the pending target.
- misaligned_o is a registered one-cycle pulse; it is not sticky.

Test Plan:
1. Reset release, no requests, WIDTH=32 → pc_o sequence is 0x0, 0x4, 0x8, 0xC on successive cycles; pc_valid_o=0 during reset and 1 from the first post-reset cycle.
2. pc_o=0x10 with branch_taken_i=1 and target 0x200, jump_i=1 with target 0x300 in the same cycle → next pc_o=0x200; the cycle after, pc_o=0x204.
3. stall_i=1 for 3 cycles with jump_i=1 (target 0x400) in the first stall cycle → pc_o holds and redirect_pending_o=1 for the remaining stall cycles; pc_o=0x400 one cycle after stall drops; redirect_pending_o returns to 0.
4. stall_i=1 with exc_i=1 and exc_pc_i=0x1C → next cycle pc_o=0x80 and epc_o=0x1C despite the stall; a later eret_i with stall_i=0 → pc_o=0x1C.
5. branch target 0x202 → pc_o=0x200 and misaligned_o=1 for exactly one cycle.
6. pc_o=0xFFFF_FFFC, sequential step → pc_o=0x0. Separately, reset asserted while in HOLD with target 0x500 → pc_o=RESET_VECTOR, redirect_pending_o=0, and 0x500 is never fetched.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer at the head of IF: picks the next fetch PC from
// sequential, branch, jump, exception and eret sources and owns the EPC.
// Latency: one clock from request to new pc; pc_plus is combinational from pc.
// Backpressure: stall freezes pc, and a redirect arriving during the stall is
// parked until release. Exceptions and reset are never held back.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   stall_i             freeze the fetch PC (hazard unit)
//   branch_taken_i/target, jump_i/target, exc_i/exc_pc_i, eret_i
//                       redirect requests, priority exc > eret > branch > jump
//   pc_o, pc_plus_o     current fetch PC and PC + INSTR_BYTES
//   pc_valid_o          pc_o is fetchable (1 from first cycle after reset)
//   epc_o               exception PC register
//   redirect_pending_o  a redirect is parked waiting for the stall to drop
//   misaligned_o        one-cycle pulse: the applied target had low bits set
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter int               INSTR_BYTES  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             exc_i,
    input  logic [WIDTH-1:0] exc_pc_i,
    input  logic             eret_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus_o,
    output logic             pc_valid_o,
    output logic [WIDTH-1:0] epc_o,
    output logic             redirect_pending_o,
    output logic             misaligned_o
);

    // Low address bits that must be zero in an instruction address. With
    // INSTR_BYTES = 1 the mask is empty and nothing is ever misaligned.
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INSTR_BYTES - 1);
    localparam logic [WIDTH-1:0] STEP     = WIDTH'(INSTR_BYTES);

    // RUN : pc advances or redirects freely (subject to stall).
    // HOLD: a redirect is parked in pend_tgt_q until stall releases.
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pend_mis_q, pend_mis_d;
    logic             mis_q, mis_d;
    logic             valid_q;

    // Live (this-cycle) redirect, excluding exceptions which bypass the FSM.
    logic             live_req;
    logic [WIDTH-1:0] live_raw;
    logic [WIDTH-1:0] live_tgt;
    logic             live_mis;

    // ------------------------------------------------------------------
    // Live redirect selection and alignment
    // ------------------------------------------------------------------
    always_comb begin
        live_req = eret_i | branch_taken_i | jump_i;
        live_raw = '0;
        if (eret_i) begin
            live_raw = epc_q;
        end else if (branch_taken_i) begin
            live_raw = branch_target_i;
        end else if (jump_i) begin
            live_raw = jump_target_i;
        end
        live_tgt = live_raw & ~LOW_MASK;
        live_mis = |(live_raw & LOW_MASK);
    end

    // ------------------------------------------------------------------
    // State register (with the datapath registers it sequences)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            pend_tgt_q <= '0;
            pend_mis_q <= 1'b0;
            mis_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_mis_q <= pend_mis_d;
            mis_q      <= mis_d;
            valid_q    <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        pend_tgt_d = pend_tgt_q;
        pend_mis_d = pend_mis_q;
        mis_d      = 1'b0;

        if (exc_i) begin
            // Exception wins over everything, even a stall, and drops any
            // parked redirect. The vector is aligned by construction.
            pc_d       = EXC_VECTOR;
            epc_d      = exc_pc_i;
            pend_mis_d = 1'b0;
            state_d    = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!stall_i) begin
                        if (live_req) begin
                            pc_d  = live_tgt;
                            mis_d = live_mis;
                        end else begin
                            pc_d = pc_q + STEP;
                        end
                    end else if (live_req) begin
                        pend_tgt_d = live_tgt;
                        pend_mis_d = live_mis;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (stall_i) begin
                        // Latest redirect wins while frozen.
                        if (live_req) begin
                            pend_tgt_d = live_tgt;
                            pend_mis_d = live_mis;
                        end
                    end else begin
                        // Release: a redirect arriving on the release cycle is
                        // younger than the parked one and takes precedence.
                        state_d    = RUN;
                        pend_mis_d = 1'b0;
                        if (live_req) begin
                            pc_d  = live_tgt;
                            mis_d = live_mis;
                        end else begin
                            pc_d  = pend_tgt_q;
                            mis_d = pend_mis_q;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_o               = pc_q;
        pc_plus_o          = pc_q + STEP;
        pc_valid_o         = valid_q;
        epc_o              = epc_q;
        redirect_pending_o = (state_q == HOLD);
        misaligned_o       = mis_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps followed by random
// traffic, every cycle compared against a behavioural model of the PC rules.
module tb_pc_sequencer;

    localparam int          W    = 32;
    localparam int          IB   = 4;
    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] EXCV = 32'h0000_0080;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          br;
    logic [W-1:0]  br_tgt;
    logic          jmp;
    logic [W-1:0]  jmp_tgt;
    logic          exc;
    logic [W-1:0]  exc_pc;
    logic          eret;
    logic [W-1:0]  pc;
    logic [W-1:0]  pc_plus;
    logic          pc_valid;
    logic [W-1:0]  epc;
    logic          pending;
    logic          mis;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_valid;
    logic        m_pend;
    logic [31:0] m_ptgt;
    logic        m_pmis;
    logic        m_mis;

    always #5 clk = ~clk;

    pc_sequencer #(
        .WIDTH(W), .INSTR_BYTES(IB), .RESET_VECTOR(RV), .EXC_VECTOR(EXCV)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall_i            (stall),
        .branch_taken_i     (br),
        .branch_target_i    (br_tgt),
        .jump_i             (jmp),
        .jump_target_i      (jmp_tgt),
        .exc_i              (exc),
        .exc_pc_i           (exc_pc),
        .eret_i             (eret),
        .pc_o               (pc),
        .pc_plus_o          (pc_plus),
        .pc_valid_o         (pc_valid),
        .epc_o              (epc),
        .redirect_pending_o (pending),
        .misaligned_o       (mis)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; br = 1'b0; jmp = 1'b0; exc = 1'b0; eret = 1'b0;
        br_tgt = '0; jmp_tgt = '0; exc_pc = '0;
    endtask

    // Model of one clock edge, written straight from the PC rules.
    task automatic model_step();
        logic        have;
        logic [31:0] raw;
        if (reset) begin
            m_pc = RV; m_epc = 0; m_valid = 0; m_pend = 0; m_mis = 0;
        end else begin
            m_valid = 1;
            m_mis   = 0;
            have    = eret || br || jmp;
            raw     = eret ? m_epc : (br ? br_tgt : jmp_tgt);
            if (exc) begin
                m_pc = EXCV; m_epc = exc_pc; m_pend = 0;
            end else if (stall) begin
                if (have) begin
                    m_pend = 1;
                    m_ptgt = raw - (raw % IB);
                    m_pmis = (raw % IB) != 0;
                end
            end else if (have) begin
                m_pc = raw - (raw % IB); m_mis = (raw % IB) != 0; m_pend = 0;
            end else if (m_pend) begin
                m_pc = m_ptgt; m_mis = m_pmis; m_pend = 0;
            end else begin
                m_pc = m_pc + IB;
            end
        end
    endtask

    // Clock once with the inputs currently driven, then compare everything.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pc",       pc,       m_pc);
        chk("pc_plus",  pc_plus,  m_pc + IB);
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
        chk("epc",      epc,      m_epc);
        chk("pending",  {31'd0, pending},  {31'd0, m_pend});
        chk("mis",      {31'd0, mis},      {31'd0, m_mis});
    endtask

    initial begin
        m_pc = 0; m_epc = 0; m_valid = 0; m_pend = 0; m_ptgt = 0; m_pmis = 0; m_mis = 0;
        idle_inputs();

        // 1: reset then sequential fetch
        reset = 1'b1;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'd0, pc_valid}, 32'd0);
        reset = 1'b0;
        tick(); chk("seq_4", pc, 32'h4); chk("valid_after_rst", {31'd0, pc_valid}, 32'd1);
        tick(); chk("seq_8", pc, 32'h8);
        tick(); chk("seq_c", pc, 32'hC);
        tick(); chk("seq_10", pc, 32'h10);

        // 2: branch beats jump
        br = 1; br_tgt = 32'h200; jmp = 1; jmp_tgt = 32'h300;
        tick(); chk("br_prio", pc, 32'h200);
        idle_inputs();
        tick(); chk("br_seq", pc, 32'h204);

        // 3: jump during stall is parked and applied on release
        stall = 1; jmp = 1; jmp_tgt = 32'h400;
        tick(); chk("stall_hold", pc, 32'h204); chk("pend_set", {31'd0, pending}, 32'd1);
        jmp = 0;
        tick(); tick(); chk("stall_hold3", pc, 32'h204);
        stall = 0;
        tick(); chk("release_pc", pc, 32'h400); chk("pend_clr", {31'd0, pending}, 32'd0);

        // 4: exception ignores stall; eret returns to EPC
        stall = 1; exc = 1; exc_pc = 32'h1C;
        tick(); chk("exc_pc", pc, 32'h80); chk("exc_epc", epc, 32'h1C);
        idle_inputs();
        tick(); chk("exc_seq", pc, 32'h84);
        eret = 1;
        tick(); chk("eret_pc", pc, 32'h1C);
        idle_inputs();

        // 5: misaligned branch target
        br = 1; br_tgt = 32'h202;
        tick(); chk("mis_pc", pc, 32'h200); chk("mis_pulse", {31'd0, mis}, 32'd1);
        idle_inputs();
        tick(); chk("mis_clear", {31'd0, mis}, 32'd0); chk("mis_seq", pc, 32'h204);

        // 6a: wraparound
        jmp = 1; jmp_tgt = 32'hFFFF_FFFC;
        tick(); chk("wrap_pre", pc, 32'hFFFF_FFFC);
        idle_inputs();
        tick(); chk("wrap", pc, 32'h0);

        // 6b: reset while HOLD discards the parked redirect
        stall = 1; jmp = 1; jmp_tgt = 32'h500;
        tick(); chk("hold_pend", {31'd0, pending}, 32'd1);
        jmp = 0;
        tick();
        reset = 1; stall = 0;
        tick(); chk("rst_hold_pc", pc, RV); chk("rst_hold_pend", {31'd0, pending}, 32'd0);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            assert (pc !== 32'h500) else begin
                errors++;
                $error("FAIL no_500 observed=%h expected!=%h", pc, 32'h500);
            end
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            reset   = ($urandom_range(0, 99) == 0);
            stall   = ($urandom_range(0, 2) == 0);
            exc     = ($urandom_range(0, 24) == 0);
            eret    = ($urandom_range(0, 11) == 0);
            br      = ($urandom_range(0, 5) == 0);
            jmp     = ($urandom_range(0, 5) == 0);
            br_tgt  = $urandom;
            jmp_tgt = $urandom;
            exc_pc  = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
